// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential execute-stage ALU:
//   - op_e     : 3-bit opcode encoding seen on the op port
//   - FLAG_*   : bit positions inside the {Z,V,N} flag register
//   - state_e  : control FSM states (single-cycle idle vs. iterative shift)
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NAND = 3'b010,
    OP_XOR  = 3'b011,
    OP_SLL  = 3'b100,
    OP_SRA  = 3'b101,
    OP_ROR  = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/addsub_nbit.sv
// ---------------------------------------------------------------------------
// addsub_nbit
// Purely combinational WIDTH-bit two's-complement adder/subtractor with
// signed-overflow detection. Saturation is applied by the caller.
// Ports:
//   i_a, i_b : operands
//   i_sub    : 0 = i_a + i_b, 1 = i_a - i_b
//   o_y      : wrapped WIDTH-bit result
//   o_ovf    : signed overflow of the operation
// ---------------------------------------------------------------------------
module addsub_nbit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_y,
  output logic             o_ovf
);

  logic w_signA;
  logic w_signB;
  logic w_signY;

  assign o_y     = i_sub ? (i_a - i_b) : (i_a + i_b);
  assign w_signA = i_a[WIDTH-1];
  assign w_signB = i_b[WIDTH-1];
  assign w_signY = o_y[WIDTH-1];

  // Add overflows when both operands share a sign the result lacks;
  // subtract overflows when the operand signs differ and the result sign
  // no longer matches the minuend.
  always_comb begin
    o_ovf = 1'b0;
    if (i_sub) begin
      o_ovf = (w_signA != w_signB) && (w_signY != w_signA);
    end else begin
      o_ovf = (w_signA == w_signB) && (w_signY != w_signA);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Handshaked WIDTH-bit execute-stage ALU. Arithmetic/logic ops finish in one
// cycle; SLL/SRA/ROR by k >= 1 iterate one bit per cycle while in_ready is
// held low. Results, err and the {Z,V,N} flags are registered; out_valid is
// a one-cycle pulse marking new values.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operation handshake (accept when both high)
//   op, sat             : opcode, saturate enable for ADD/SUB
//   a, b                : operands; b[SHW-1:0] is the shift amount
//   result, out_valid   : registered result and its valid pulse
//   err                 : illegal opcode, qualified by out_valid
//   flags               : persistent {Z,V,N} flag register
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             sat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             err,
  output logic [2:0]       flags
);

  state_e           r_state;
  state_e           w_stateNext;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  op_e              r_shOp;
  logic [WIDTH-1:0] r_result;
  logic             r_outValid;
  logic             r_err;
  logic [2:0]       r_flags;

  op_e              w_op;
  logic             w_inReady;
  logic             w_accept;
  logic             w_isShift;
  logic [SHW-1:0]   w_k;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_satRes;
  logic [WIDTH-1:0] w_singleRes;
  logic [WIDTH-1:0] w_accShifted;

  assign w_op      = op_e'(op);
  assign w_k       = b[SHW-1:0];
  assign w_isShift = (w_op == OP_SLL) || (w_op == OP_SRA) || (w_op == OP_ROR);
  assign w_accept  = in_valid && w_inReady;

  // One step of the iterative shifter for the latched shift opcode.
  function automatic logic [WIDTH-1:0] shiftOne(input op_e f_op,
                                                input logic [WIDTH-1:0] f_val);
    logic [WIDTH-1:0] f_out;
    f_out = f_val;
    case (f_op)
      OP_SLL:  f_out = {f_val[WIDTH-2:0], 1'b0};
      OP_SRA:  f_out = {f_val[WIDTH-1], f_val[WIDTH-1:1]};
      OP_ROR:  f_out = {f_val[0], f_val[WIDTH-1:1]};
      default: f_out = f_val;
    endcase
    return f_out;
  endfunction

  assign w_accShifted = shiftOne(r_shOp, r_acc);

  addsub_nbit #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_a   (a),
    .i_b   (b),
    .i_sub (w_op == OP_SUB),
    .o_y   (w_sum),
    .o_ovf (w_ovf)
  );

  // Saturation clamps toward the sign of a: with an overflow, a positive
  // a always means the true result exceeded the max positive value, for
  // both ADD and SUB.
  always_comb begin
    w_satRes = w_sum;
    if (sat && w_ovf) begin
      w_satRes = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Result for everything that completes in the accept cycle. A shift only
  // lands here when k = 0, in which case it passes a through unchanged.
  always_comb begin
    w_singleRes = '0;
    case (w_op)
      OP_ADD, OP_SUB:         w_singleRes = w_satRes;
      OP_NAND:                w_singleRes = ~(a & b);
      OP_XOR:                 w_singleRes = a ^ b;
      OP_SLL, OP_SRA, OP_ROR: w_singleRes = a;
      default:                w_singleRes = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state and in_ready. in_ready is suppressed during reset so nothing
  // offered then is taken; the IDLE transition repeats the accept condition
  // directly to keep in_ready out of its own fan-in.
  always_comb begin
    w_stateNext = r_state;
    w_inReady   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_inReady = !rst;
        if (in_valid && !rst && w_isShift && (w_k != '0)) begin
          w_stateNext = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == SHW'(1)) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Datapath and flag register. out_valid and err default low every cycle
  // so each completion produces exactly one pulse. V and N are only touched
  // by ADD/SUB; illegal ops leave all flags alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_shOp     <= OP_ADD;
      r_result   <= '0;
      r_outValid <= 1'b0;
      r_err      <= 1'b0;
      r_flags    <= 3'b000;
    end else begin
      r_outValid <= 1'b0;
      r_err      <= 1'b0;
      if (w_accept) begin
        case (w_op)
          OP_ADD, OP_SUB: begin
            r_result       <= w_singleRes;
            r_flags[FLAG_Z] <= (w_singleRes == '0);
            r_flags[FLAG_V] <= w_ovf;
            r_flags[FLAG_N] <= w_singleRes[WIDTH-1];
            r_outValid     <= 1'b1;
          end
          OP_NAND, OP_XOR: begin
            r_result       <= w_singleRes;
            r_flags[FLAG_Z] <= (w_singleRes == '0);
            r_outValid     <= 1'b1;
          end
          OP_SLL, OP_SRA, OP_ROR: begin
            if (w_k == '0) begin
              r_result       <= w_singleRes;
              r_flags[FLAG_Z] <= (w_singleRes == '0);
              r_outValid     <= 1'b1;
            end else begin
              r_acc  <= a;
              r_cnt  <= w_k;
              r_shOp <= w_op;
            end
          end
          default: begin
            r_result   <= '0;
            r_err      <= 1'b1;
            r_outValid <= 1'b1;
          end
        endcase
      end else if (r_state == ST_SHIFT) begin
        r_acc <= w_accShifted;
        r_cnt <= r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) begin
          r_result       <= w_accShifted;
          r_flags[FLAG_Z] <= (w_accShifted == '0);
          r_outValid     <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = w_inReady;
  assign result    = r_result;
  assign out_valid = r_outValid;
  assign err       = r_err;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed bench for alu_seq (WIDTH = 16). Accepted operations are run
// through a reference model and queued with their expected completion
// cycle; each out_valid pops and compares the head of the queue.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             sat;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             err;
  logic [2:0]       flags;

  typedef struct {
    logic [15:0] res;
    logic        err;
    logic [2:0]  flags;
    int          due;
  } exp_t;

  exp_t       sbQueue[$];
  int         checks = 0;
  int         errors = 0;
  int         cycle  = 0;
  logic [2:0] modelFlags = 3'b000;
  bit         lastAccepted;

  alu_seq #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sat       (sat),
    .a         (a),
    .b         (b),
    .result    (result),
    .out_valid (out_valid),
    .err       (err),
    .flags     (flags)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model working on integers, independent of the bit-level RTL.
  function automatic exp_t modelCompute(input logic [2:0] mOp, input logic mSat,
                                        input logic [15:0] mA, input logic [15:0] mB,
                                        input logic [2:0] fl);
    exp_t e;
    int   sa, sb, s, k;
    bit   ovf;
    e.err   = 1'b0;
    e.flags = fl;
    e.due   = 0;
    e.res   = '0;
    k       = int'(mB[3:0]);
    sa      = int'($signed(mA));
    sb      = int'($signed(mB));
    case (mOp)
      3'd0, 3'd1: begin
        s   = (mOp == 3'd0) ? sa + sb : sa - sb;
        ovf = (s > 32767) || (s < -32768);
        e.res = s[15:0];
        if (mSat && ovf) e.res = (s > 0) ? 16'h7FFF : 16'h8000;
        e.flags = {e.res == 16'h0000, ovf, e.res[15]};
      end
      3'd2: e.res = ~(mA & mB);
      3'd3: e.res = mA ^ mB;
      3'd4: e.res = mA << k;
      3'd5: e.res = $signed(mA) >>> k;
      3'd6: e.res = (k == 0) ? mA : ((mA >> k) | (mA << (16 - k)));
      default: e.err = 1'b1;
    endcase
    if (mOp inside {3'd2, 3'd3, 3'd4, 3'd5, 3'd6}) e.flags[2] = (e.res == 16'h0000);
    return e;
  endfunction

  task automatic modelReset();
    sbQueue.delete();
    modelFlags = 3'b000;
  endtask

  // One clock: record an accept, advance to the next falling edge, then
  // check whatever the DUT presented.
  task automatic tick();
    exp_t e;
    int   lat;
    #1;
    lastAccepted = (in_valid === 1'b1) && (in_ready === 1'b1) && (rst === 1'b0);
    if (lastAccepted) begin
      e   = modelCompute(op, sat, a, b, modelFlags);
      lat = (op inside {3'd4, 3'd5, 3'd6}) ? int'(b[3:0]) : 0;
      e.due = cycle + 1 + lat;
      modelFlags = e.flags;
      sbQueue.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
    if (out_valid === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedOutValid", 32'(out_valid), 32'h0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("result", 32'(result), 32'(e.res));
        checkOutput("err", 32'(err), 32'(e.err));
        checkOutput("flags", 32'(flags), 32'(e.flags));
        checkOutput("latency", 32'(cycle), 32'(e.due));
      end
    end else if (sbQueue.size() > 0 && sbQueue[0].due <= cycle) begin
      checkOutput("missingOutValid", 32'(out_valid), 32'h1);
      void'(sbQueue.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic [2:0] sOp, input logic sSat,
                               input logic [15:0] sA, input logic [15:0] sB);
    op       = sOp;
    sat      = sSat;
    a        = sA;
    b        = sB;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (lastAccepted) break;
    end
    checkOutput("accepted", 32'(lastAccepted), 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbQueue.size() > 0; i++) tick();
    checkOutput("drained", 32'(sbQueue.size()), 32'h0);
  endtask

  logic [2:0] opTable [5];

  initial begin
    opTable  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    rst      = 1'b1;
    in_valid = 1'b0;
    op       = 3'd0;
    sat      = 1'b0;
    a        = '0;
    b        = '0;
    @(negedge clk);
    tick();
    tick();
    checkOutput("rstResult", 32'(result), 32'h0);
    checkOutput("rstFlags", 32'(flags), 32'h0);
    checkOutput("rstOutValid", 32'(out_valid), 32'h0);
    checkOutput("rstErr", 32'(err), 32'h0);
    checkOutput("rstInReady", 32'(in_ready), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("idleInReady", 32'(in_ready), 32'h1);

    $display("[TB] ADD overflow, wrapped and saturated");
    applyStimulus(3'd0, 1'b0, 16'h7FFF, 16'h0001);
    drain();
    checkOutput("addWrapRes", 32'(result), 32'h8000);
    checkOutput("addWrapFlags", 32'(flags), 32'h3);
    applyStimulus(3'd0, 1'b1, 16'h7FFF, 16'h0001);
    drain();
    checkOutput("addSatRes", 32'(result), 32'h7FFF);
    checkOutput("addSatFlags", 32'(flags), 32'h2);

    $display("[TB] SUB / NAND / XOR");
    applyStimulus(3'd1, 1'b0, 16'h1234, 16'h1234);
    drain();
    checkOutput("subRes", 32'(result), 32'h0);
    checkOutput("subFlags", 32'(flags), 32'h4);
    applyStimulus(3'd2, 1'b0, 16'hFFFF, 16'hFFFF);
    drain();
    checkOutput("nandRes", 32'(result), 32'h0);
    checkOutput("nandFlags", 32'(flags), 32'h4);
    applyStimulus(3'd3, 1'b0, 16'h00F0, 16'h0F00);
    drain();
    checkOutput("xorRes", 32'(result), 32'h0FF0);
    checkOutput("xorFlags", 32'(flags), 32'h0);

    $display("[TB] Shifts");
    applyStimulus(3'd5, 1'b0, 16'h8000, 16'h0003);
    checkOutput("sraReady0", 32'(in_ready), 32'h0);
    tick();
    checkOutput("sraReady1", 32'(in_ready), 32'h0);
    tick();
    checkOutput("sraReady2", 32'(in_ready), 32'h0);
    tick();
    checkOutput("sraReadyBack", 32'(in_ready), 32'h1);
    checkOutput("sraRes", 32'(result), 32'hF000);
    drain();
    applyStimulus(3'd6, 1'b0, 16'h0001, 16'h0001);
    drain();
    checkOutput("rorRes", 32'(result), 32'h8000);
    applyStimulus(3'd4, 1'b0, 16'h1234, 16'h0000);
    drain();
    checkOutput("sll0Res", 32'(result), 32'h1234);

    $display("[TB] Illegal opcode");
    applyStimulus(3'd0, 1'b0, 16'h8000, 16'h8000);
    drain();
    checkOutput("preIllFlags", 32'(flags), 32'h6);
    applyStimulus(3'd7, 1'b0, 16'hFFFF, 16'h0000);
    drain();
    checkOutput("illRes", 32'(result), 32'h0);
    checkOutput("illFlags", 32'(flags), 32'h6);
    tick();
    checkOutput("illErrPulse", 32'(err), 32'h0);
    applyStimulus(3'd0, 1'b0, 16'h0001, 16'h0001);
    drain();
    checkOutput("postIllRes", 32'(result), 32'h2);

    $display("[TB] Reset during shift");
    applyStimulus(3'd4, 1'b0, 16'h0001, 16'h000F);
    repeat (5) tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    op       = 3'd0;
    a        = 16'h0002;
    b        = 16'h0003;
    tick();
    checkOutput("midRstInReady", 32'(in_ready), 32'h0);
    checkOutput("midRstResult", 32'(result), 32'h0);
    checkOutput("midRstFlags", 32'(flags), 32'h0);
    modelReset();
    tick();
    checkOutput("midRstOutValid", 32'(out_valid), 32'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("postRstInReady", 32'(in_ready), 32'h1);
    repeat (20) tick();
    applyStimulus(3'd0, 1'b0, 16'h0002, 16'h0003);
    drain();
    checkOutput("postRstAdd", 32'(result), 32'h5);

    $display("[TB] Back-to-back random stream");
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      op  = opTable[$urandom_range(0, 4)];
      sat = 1'($urandom_range(0, 1));
      a   = 16'($urandom);
      b   = 16'($urandom);
      tick();
      checkOutput("streamOutValid", 32'(out_valid), 32'h1);
    end
    in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
